// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser: FSM state encoding,
// error codes reported with a discarded frame, default frame delimiter, and
// the 8-bit wrapping checksum accumulate.
package uart_pkg;

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Running checksum: LEN plus payload bytes, modulo 256.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, one synchronous write port and
// one asynchronous read port. Contents are not reset; the parser only reads
// entries it has written for the current frame.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Store one payload byte per accepted receive strobe.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// UART frame parser: hunts for SYNC, takes LEN and LEN payload bytes, checks
// the trailing two's-complement checksum, then replays the buffered payload on
// a valid/ready stream with o_Last on the final byte. Bad LEN, bad checksum and
// mid-frame silence discard the frame and pulse o_Frame_Err with a code.
//
// state     | meaning
// S_SYNC    | waiting for the delimiter byte, other bytes ignored
// S_LEN     | waiting for the length byte
// S_PAYLOAD | collecting payload bytes into the buffer
// S_CHK     | waiting for the checksum byte
// S_DRAIN   | replaying the validated payload, incoming bytes dropped
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter logic [15:0] TIMEOUT_CLKS = 16'd2000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  input  logic       i_Ready,
  output logic       o_Last,
  output logic       o_Frame_Ok,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [LW-1:0] IDX_ONE   = LW'(1);

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] wr_idx_q, wr_idx_d;
  logic [LW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          overrun_q, overrun_d;

  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic [7:0]    sum_next;
  logic          tmo_expired;
  logic          rd_is_last;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i   (i_Clock),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q[AW-1:0]),
    .wdata_i (i_Rx_Byte),
    .raddr_i (rd_idx_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  assign sum_next    = sum8(sum_q, i_Rx_Byte);
  assign tmo_expired = (tmo_q == TIMEOUT_CLKS - 16'd1);
  assign rd_is_last  = (rd_idx_q == len_q - IDX_ONE);

  // Drain outputs come straight from state and the buffer read port, so they
  // hold steady under backpressure and drop to zero immediately on reset.
  assign o_Valid     = (state_q == S_DRAIN);
  assign o_Data      = o_Valid ? buf_rdata : 8'h00;
  assign o_Last      = o_Valid && rd_is_last;
  assign o_Frame_Ok  = frame_ok_q;
  assign o_Frame_Err = frame_err_q;
  assign o_Err_Code  = err_code_q;
  assign o_Overrun   = overrun_q;

  // Next-state, datapath updates and status pulse generation. A receive
  // strobe always takes priority over an expiring idle timer.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    sum_d       = sum_q;
    tmo_d       = 16'd0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = ERR_NONE;
    overrun_d   = 1'b0;
    buf_we      = 1'b0;

    unique case (state_q)
      S_SYNC: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (i_Rx_DV) begin
          if ((i_Rx_Byte == 8'h00) || (i_Rx_Byte > MAX_LEN_B)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_SYNC;
          end else begin
            len_d    = i_Rx_Byte[LW-1:0];
            sum_d    = i_Rx_Byte;
            wr_idx_d = '0;
            state_d  = S_PAYLOAD;
          end
        end else if (tmo_expired) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_SYNC;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_PAYLOAD: begin
        if (i_Rx_DV) begin
          buf_we   = 1'b1;
          sum_d    = sum_next;
          wr_idx_d = wr_idx_q + IDX_ONE;
          if (wr_idx_q == len_q - IDX_ONE) begin
            state_d = S_CHK;
          end
        end else if (tmo_expired) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_SYNC;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_CHK: begin
        if (i_Rx_DV) begin
          if (sum_next == 8'h00) begin
            frame_ok_d = 1'b1;
            rd_idx_d   = '0;
            state_d    = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = S_SYNC;
          end
        end else if (tmo_expired) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_SYNC;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_DRAIN: begin
        if (i_Rx_DV) begin
          overrun_d = 1'b1;
        end
        if (i_Ready) begin
          rd_idx_d = rd_idx_q + IDX_ONE;
          if (rd_is_last) begin
            state_d = S_SYNC;
          end
        end
      end

      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  // State, datapath and status registers; async reset returns to sync hunt.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= S_SYNC;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      sum_q       <= 8'h00;
      tmo_q       <= 16'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: byte streams are parsed by a frame-level
// reference model into expected status codes and payload beats, and the
// DUT's observed pulses/beats are compared against them.
module tb_uart_rx_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         TMO     = 2000;

  logic       i_Clock = 1'b0;
  logic       i_Reset;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       i_Ready;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_Last;
  logic       o_Frame_Ok;
  logic       o_Frame_Err;
  logic [1:0] o_Err_Code;
  logic       o_Overrun;

  uart_rx_frame_parser #(
    .MAX_LEN      (MAX_LEN),
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_CLKS (16'(TMO))
  ) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .o_Data      (o_Data),
    .o_Valid     (o_Valid),
    .i_Ready     (i_Ready),
    .o_Last      (o_Last),
    .o_Frame_Ok  (o_Frame_Ok),
    .o_Frame_Err (o_Frame_Err),
    .o_Err_Code  (o_Err_Code),
    .o_Overrun   (o_Overrun)
  );

  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [7:0] stream[$];
  logic [1:0] exp_err[$];
  logic [1:0] obs_err[$];
  logic [8:0] exp_beat[$];
  logic [8:0] obs_beat[$];
  int exp_ok = 0;
  int obs_ok = 0;
  int obs_ovr = 0;
  int viol = 0;
  int err_cyc = 0;
  int last_dv_cyc = 0;
  int rdy_mode = 0;
  int rk = 0;

  bit       pv = 0, pr = 0, pl = 0, pok = 0, perr = 0;
  logic [7:0] pd = 8'h00;

  // Observe outputs mid-cycle: record pulses and beats, flag protocol breaks.
  always @(negedge i_Clock) begin
    if (i_Reset) begin
      pv = 0; pr = 0; pl = 0; pok = 0; perr = 0;
    end else begin
      if (o_Frame_Ok) begin
        obs_ok++;
        if (pok) viol++;
        if (!o_Valid) viol++;
      end
      if (o_Frame_Err) begin
        obs_err.push_back(o_Err_Code);
        err_cyc = cyc;
        if (perr) viol++;
      end else if (o_Err_Code != 2'b00) viol++;
      if (o_Frame_Ok && o_Frame_Err) viol++;
      if (o_Overrun) obs_ovr++;
      if (o_Valid && !pv && !o_Frame_Ok) viol++;
      if (pv && !pr && (!o_Valid || o_Data !== pd || o_Last !== pl)) viol++;
      if (pv && pr && pl && o_Valid) viol++;
      if (o_Valid && i_Ready) obs_beat.push_back({o_Last, o_Data});
      pv = o_Valid; pr = i_Ready; pd = o_Data; pl = o_Last;
      pok = o_Frame_Ok; perr = o_Frame_Err;
    end
  end

  // Consumer readiness pattern selected by rdy_mode.
  initial begin
    i_Ready = 1'b1;
    forever begin
      @(posedge i_Clock);
      #1;
      case (rdy_mode)
        0: i_Ready = 1'b1;
        1: i_Ready = ((rk % 4) == 0) || ((rk % 4) == 3);
        2: i_Ready = 1'b0;
        default: i_Ready = 1'($urandom_range(0, 1));
      endcase
      rk++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(posedge i_Clock);
    #1;
    last_dv_cyc = cyc;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'($urandom);
    step(gap);
  endtask

  task automatic send_stream();
    for (int k = 0; k < stream.size(); k++) send_byte(stream[k], int'($urandom_range(0, 3)));
  endtask

  task automatic clear_all();
    obs_err.delete(); exp_err.delete();
    obs_beat.delete(); exp_beat.delete();
    obs_ok = 0; exp_ok = 0; obs_ovr = 0;
  endtask

  // Frame-level reference: walk the byte list, silence assumed after the end.
  task automatic model();
    int i, n, L, s;
    i = 0;
    n = stream.size();
    while (i < n) begin
      if (stream[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 1 >= n) begin
        exp_err.push_back(2'b11);
        break;
      end
      L = int'(stream[i+1]);
      if (L == 0 || L > MAX_LEN) begin
        exp_err.push_back(2'b01);
        i += 2;
        continue;
      end
      if (i + 2 + L >= n) begin
        exp_err.push_back(2'b11);
        break;
      end
      s = L;
      for (int k = 0; k <= L; k++) s += int'(stream[i+2+k]);
      if ((s % 256) == 0) begin
        exp_ok++;
        for (int k = 0; k < L; k++) exp_beat.push_back({(k == L - 1), stream[i+2+k]});
      end else begin
        exp_err.push_back(2'b10);
      end
      i += 3 + L;
    end
  endtask

  task automatic add_frame(input int L, input bit corrupt);
    int s;
    logic [7:0] b, chk;
    stream.push_back(SYNC);
    stream.push_back(8'(L));
    s = L;
    for (int k = 0; k < L; k++) begin
      b = 8'($urandom);
      stream.push_back(b);
      s += int'(b);
    end
    chk = 8'((256 - (s % 256)) % 256);
    if (corrupt) chk = chk ^ 8'(1 << $urandom_range(0, 7));
    stream.push_back(chk);
  endtask

  task automatic compare_stream(input string tag);
    int budget;
    budget = 6000;
    while (budget > 0 && (obs_beat.size() < exp_beat.size() || obs_ok < exp_ok ||
                          obs_err.size() < exp_err.size())) begin
      step(1);
      budget--;
    end
    step(4);
    check({tag, ".ok"}, 32'(obs_ok), 32'(exp_ok));
    check({tag, ".nerr"}, 32'(obs_err.size()), 32'(exp_err.size()));
    for (int k = 0; k < exp_err.size(); k++)
      if (k < obs_err.size()) check({tag, ".code"}, 32'(obs_err[k]), 32'(exp_err[k]));
    check({tag, ".nbeat"}, 32'(obs_beat.size()), 32'(exp_beat.size()));
    for (int k = 0; k < exp_beat.size(); k++)
      if (k < obs_beat.size()) check({tag, ".beat"}, 32'(obs_beat[k]), 32'(exp_beat[k]));
    clear_all();
  endtask

  task automatic run_stream(input string tag);
    model();
    send_stream();
    compare_stream(tag);
    stream.delete();
  endtask

  int         ng, kind;
  logic [7:0] gb;

  initial begin
    i_Reset   = 1'b1;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
    step(3);
    check("rst.valid", 32'(o_Valid), 32'd0);
    check("rst.data", 32'(o_Data), 32'd0);
    check("rst.status", 32'({o_Last, o_Frame_Ok, o_Frame_Err, o_Err_Code, o_Overrun}), 32'd0);
    i_Reset = 1'b0;
    step(2);

    stream = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    run_stream("good");

    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    run_stream("badchk");
    stream = '{8'hA5, 8'h01, 8'h5A, 8'hA5};
    run_stream("afterbad");

    stream = '{8'hA5, 8'h00};
    run_stream("len0");
    stream = '{8'hA5, 8'h11};
    run_stream("len17");
    add_frame(MAX_LEN, 1'b0);
    run_stream("lenmax");

    stream = '{8'hA5, 8'h02, 8'h11};
    run_stream("tmo");
    check("tmo.delay", 32'(err_cyc - last_dv_cyc), 32'(TMO));

    stream = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'hCB};
    model();
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h11, 0);
    begin
      int target;
      target = last_dv_cyc + TMO - 1;
      while (cyc < target) step(1);
    end
    send_byte(8'h22, 0);
    send_byte(8'hCB, 0);
    compare_stream("tmo_race");
    stream.delete();

    rdy_mode = 1;
    add_frame(10, 1'b0);
    run_stream("bp");
    check("bp.proto", 32'(viol), 32'd0);

    rdy_mode = 2;
    add_frame(4, 1'b0);
    model();
    send_stream();
    step(3);
    send_byte(SYNC, 2);
    send_byte(8'h03, 2);
    check("ovr.count", 32'(obs_ovr), 32'd2);
    rdy_mode = 0;
    compare_stream("ovr");
    stream.delete();
    add_frame(3, 1'b0);
    run_stream("post_ovr");

    send_byte(8'hA5, 1);
    send_byte(8'h04, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    #2 i_Reset = 1'b1;
    #1 check("rst_mid.out", 32'({o_Valid, o_Last, o_Frame_Ok, o_Frame_Err, o_Err_Code, o_Overrun, o_Data}), 32'd0);
    step(1);
    i_Reset = 1'b0;
    step(1);
    clear_all();
    add_frame(4, 1'b0);
    run_stream("post_rst");

    rdy_mode = 2;
    add_frame(5, 1'b0);
    send_stream();
    step(2);
    check("rst_drain.pre", 32'(o_Valid), 32'd1);
    #2 i_Reset = 1'b1;
    #1 check("rst_drain.valid", 32'(o_Valid), 32'd0);
    check("rst_drain.data", 32'(o_Data), 32'd0);
    step(1);
    i_Reset = 1'b0;
    rdy_mode = 0;
    step(1);
    clear_all();
    stream.delete();
    step(10);
    check("rst_drain.nobeat", 32'(obs_beat.size()), 32'd0);
    add_frame(MAX_LEN, 1'b0);
    run_stream("post_rst2");

    rdy_mode = 3;
    for (int it = 0; it < 25; it++) begin
      ng = int'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 9));
      stream.delete();
      for (int g = 0; g < ng; g++) begin
        do gb = 8'($urandom); while (gb == SYNC);
        stream.push_back(gb);
      end
      if (kind == 0) begin
        stream.push_back(SYNC);
        if ($urandom_range(0, 1) == 0) stream.push_back(8'h00);
        else stream.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        add_frame(int'($urandom_range(1, MAX_LEN)), kind <= 2);
      end
      run_stream("rnd");
    end

    check("proto.viol", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
